// File: rtl/cpu_sequencer_p_if.sv
// Bundle between the multi-cycle control sequencer and the datapath:
// IR/CON_FF/handshake inputs, every datapath strobe, and run/trap status.
interface cpu_sequencer_p_if #(
  parameter int REG_COUNT = 16,
  parameter int CNT_WIDTH = 32
);
  logic [31:0]          IR;
  logic                 CON_FF;
  logic                 Mem_ready;
  logic                 Stop;

  logic PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic MAR_enable, PC_enable, IncPC, MDR_enable, MDR_read, IR_enable, Y_enable;
  logic ZHighIn, ZLowIn, HIin, LOin, RAM_write, Gra, Grb, Grc, R_enable;
  logic CON_enable, OutPort_enable;

  logic [REG_COUNT-1:0] R_enableIn;
  logic                 Run;
  logic                 Illegal;
  logic [CNT_WIDTH-1:0] Instr_count;

  modport master (
    input  IR, CON_FF, Mem_ready, Stop,
    output PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
    output MAR_enable, PC_enable, IncPC, MDR_enable, MDR_read, IR_enable, Y_enable,
    output ZHighIn, ZLowIn, HIin, LOin, RAM_write, Gra, Grb, Grc, R_enable,
    output CON_enable, OutPort_enable, R_enableIn, Run, Illegal, Instr_count
  );

  modport slave (
    output IR, CON_FF, Mem_ready, Stop,
    input  PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
    input  MAR_enable, PC_enable, IncPC, MDR_enable, MDR_read, IR_enable, Y_enable,
    input  ZHighIn, ZLowIn, HIin, LOin, RAM_write, Gra, Grb, Grc, R_enable,
    input  CON_enable, OutPort_enable, R_enableIn, Run, Illegal, Instr_count
  );
endinterface

// File: rtl/cpu_sequencer_p.sv
// Moore control sequencer: fetch, decode IR[31:27], then one register-transfer
// step per clock. Outputs are registered from the next-state decode.
module cpu_sequencer_p #(
  parameter int REG_COUNT = 16,
  parameter int JAL_REG   = 15,
  parameter int CNT_WIDTH = 32
) (
  input logic                 Clock,
  input logic                 Reset,
  cpu_sequencer_p_if.master   bus
);

  typedef enum logic [3:0] {
    S_RESET, S_F0, S_F1, S_F2, S_DEC, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_ADD  = 5'b00001, OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_MUL  = 5'b00011, OP_DIV  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_NEG  = 5'b00111, OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_LDI  = 5'b01001, OP_SHL  = 5'b01010, OP_SHR  = 5'b01011;
  localparam logic [4:0] OP_ROL  = 5'b01100, OP_ROR  = 5'b01101, OP_ST   = 5'b01110;
  localparam logic [4:0] OP_ADDI = 5'b01111, OP_ANDI = 5'b10000, OP_ORI  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_MFHI = 5'b10101, OP_MFLO = 5'b10111, OP_IN   = 5'b11000;
  localparam logic [4:0] OP_OUT  = 5'b11001, OP_NOP  = 5'b11010, OP_HALT = 5'b11011;

  typedef struct packed {
    logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, inport_out, c_out;
    logic ba_out, r_out, mar_enable, pc_enable, inc_pc, mdr_enable, mdr_read;
    logic ir_enable, y_enable, zhigh_in, zlow_in, hi_in, lo_in, ram_write;
    logic gra, grb, grc, r_enable, con_enable, outport_enable;
  } strobes_t;

  function automatic logic is_rtype(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ROL, OP_ROR};
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {OP_MUL, OP_DIV};
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return op inside {OP_NEG, OP_NOT};
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return op inside {OP_ADDI, OP_ANDI, OP_ORI};
  endfunction

  // ldi/ld/st all form an effective address from BAout + C
  function automatic logic is_base(input logic [4:0] op);
    return op inside {OP_LDI, OP_LD, OP_ST};
  endfunction

  function automatic logic is_single(input logic [4:0] op);
    return op inside {OP_JR, OP_MFHI, OP_MFLO, OP_IN, OP_OUT, OP_NOP};
  endfunction

  function automatic logic is_illegal(input logic [4:0] op);
    return (op == 5'b10110) || (op[4:2] == 3'b111);
  endfunction

  state_t               state_q, state_d;
  logic [4:0]           opc_q, opc_d;
  logic                 stop_q, stop_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  strobes_t             strb_q, strb_d;
  logic [REG_COUNT-1:0] rin_q, rin_d;
  logic                 run_q, run_d;
  logic                 last_step;

  logic unused_ir_bits;
  assign unused_ir_bits = ^bus.IR[26:0];

  always_comb begin : next_state
    state_d   = state_q;
    opc_d     = opc_q;
    stop_d    = stop_q | bus.Stop;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    last_step = 1'b0;
    case (state_q)
      S_RESET: state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1:    if (bus.Mem_ready) state_d = S_F2;
      S_F2:    state_d = S_DEC;
      S_DEC: begin
        opc_d = bus.IR[31:27];
        if (bus.IR[31:27] == OP_HALT) begin
          state_d = S_HALT;
        end else if (is_illegal(bus.IR[31:27])) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_T3;
        end
      end
      S_T3: if (is_single(opc_q)) last_step = 1'b1; else state_d = S_T4;
      S_T4: if (is_unary(opc_q) || opc_q == OP_JAL) last_step = 1'b1; else state_d = S_T5;
      S_T5: begin
        if (is_rtype(opc_q) || is_imm(opc_q) || opc_q == OP_LDI) last_step = 1'b1;
        else state_d = S_T6;
      end
      S_T6: begin
        if (is_muldiv(opc_q) || opc_q == OP_BR) last_step = 1'b1;
        else if (opc_q == OP_ST || bus.Mem_ready) state_d = S_T7;
      end
      S_T7: if (opc_q == OP_LD || bus.Mem_ready) last_step = 1'b1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    // a Stop arriving on the retiring edge still lands in HALT
    if (last_step) begin
      cnt_d   = cnt_q + CNT_WIDTH'(1);
      state_d = stop_d ? S_HALT : S_F0;
    end
  end

  always_comb begin : decode_outputs
    strb_d = '0;
    rin_d  = '0;
    run_d  = (state_d != S_HALT);
    case (state_d)
      S_F0: begin
        strb_d.pc_out = 1'b1; strb_d.mar_enable = 1'b1;
        strb_d.inc_pc = 1'b1; strb_d.pc_enable  = 1'b1;
      end
      S_F1: begin strb_d.mdr_read = 1'b1; strb_d.mdr_enable = 1'b1; end
      S_F2: begin strb_d.mdr_out = 1'b1; strb_d.ir_enable = 1'b1; end
      S_T3: begin
        if (is_rtype(opc_d) || is_muldiv(opc_d) || is_imm(opc_d)) begin
          strb_d.grb = 1'b1; strb_d.r_out = 1'b1; strb_d.y_enable = 1'b1;
        end else if (is_base(opc_d)) begin
          strb_d.grb = 1'b1; strb_d.ba_out = 1'b1; strb_d.y_enable = 1'b1;
        end else if (is_unary(opc_d)) begin
          strb_d.grb = 1'b1; strb_d.r_out = 1'b1;
          strb_d.zhigh_in = 1'b1; strb_d.zlow_in = 1'b1;
        end else begin
          case (opc_d)
            OP_BR:   begin strb_d.gra = 1'b1; strb_d.r_out = 1'b1; strb_d.con_enable = 1'b1; end
            OP_JR:   begin strb_d.gra = 1'b1; strb_d.r_out = 1'b1; strb_d.pc_enable = 1'b1; end
            OP_JAL:  begin strb_d.pc_out = 1'b1; rin_d = REG_COUNT'(1) << JAL_REG; end
            OP_MFHI: begin strb_d.gra = 1'b1; strb_d.r_enable = 1'b1; strb_d.hi_out = 1'b1; end
            OP_MFLO: begin strb_d.gra = 1'b1; strb_d.r_enable = 1'b1; strb_d.lo_out = 1'b1; end
            OP_IN:   begin strb_d.gra = 1'b1; strb_d.r_enable = 1'b1; strb_d.inport_out = 1'b1; end
            OP_OUT:  begin strb_d.gra = 1'b1; strb_d.r_out = 1'b1; strb_d.outport_enable = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (is_rtype(opc_d) || is_muldiv(opc_d)) begin
          strb_d.grc = 1'b1; strb_d.r_out = 1'b1;
          strb_d.zhigh_in = 1'b1; strb_d.zlow_in = 1'b1;
        end else if (is_imm(opc_d) || is_base(opc_d)) begin
          strb_d.c_out = 1'b1; strb_d.zhigh_in = 1'b1; strb_d.zlow_in = 1'b1;
        end else if (is_unary(opc_d)) begin
          strb_d.zlow_out = 1'b1; strb_d.gra = 1'b1; strb_d.r_enable = 1'b1;
        end else if (opc_d == OP_BR) begin
          strb_d.pc_out = 1'b1; strb_d.y_enable = 1'b1;
        end else if (opc_d == OP_JAL) begin
          strb_d.gra = 1'b1; strb_d.r_out = 1'b1; strb_d.pc_enable = 1'b1;
        end
      end
      S_T5: begin
        if (is_rtype(opc_d) || is_imm(opc_d) || opc_d == OP_LDI) begin
          strb_d.zlow_out = 1'b1; strb_d.gra = 1'b1; strb_d.r_enable = 1'b1;
        end else if (is_muldiv(opc_d)) begin
          strb_d.zlow_out = 1'b1; strb_d.lo_in = 1'b1;
        end else if (opc_d == OP_LD || opc_d == OP_ST) begin
          strb_d.zlow_out = 1'b1; strb_d.mar_enable = 1'b1;
        end else if (opc_d == OP_BR) begin
          strb_d.c_out = 1'b1; strb_d.zhigh_in = 1'b1; strb_d.zlow_in = 1'b1;
        end
      end
      S_T6: begin
        if (is_muldiv(opc_d)) begin
          strb_d.zhigh_out = 1'b1; strb_d.hi_in = 1'b1;
        end else if (opc_d == OP_LD) begin
          strb_d.mdr_read = 1'b1; strb_d.mdr_enable = 1'b1;
        end else if (opc_d == OP_ST) begin
          strb_d.gra = 1'b1; strb_d.r_out = 1'b1; strb_d.mdr_enable = 1'b1;
        end else if (opc_d == OP_BR) begin
          strb_d.zlow_out  = 1'b1;
          strb_d.pc_enable = bus.CON_FF;
        end
      end
      S_T7: begin
        strb_d.mdr_out = 1'b1;
        if (opc_d == OP_LD) begin strb_d.gra = 1'b1; strb_d.r_enable = 1'b1; end
        else                     strb_d.ram_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_RESET;
      opc_q     <= '0;
      stop_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      strb_q    <= '0;
      rin_q     <= '0;
      run_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      stop_q    <= stop_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      strb_q    <= strb_d;
      rin_q     <= rin_d;
      run_q     <= run_d;
    end
  end

  assign bus.PCout          = strb_q.pc_out;
  assign bus.ZHighout       = strb_q.zhigh_out;
  assign bus.ZLowout        = strb_q.zlow_out;
  assign bus.MDRout         = strb_q.mdr_out;
  assign bus.HIout          = strb_q.hi_out;
  assign bus.LOout          = strb_q.lo_out;
  assign bus.InPortout      = strb_q.inport_out;
  assign bus.Cout           = strb_q.c_out;
  assign bus.BAout          = strb_q.ba_out;
  assign bus.Rout           = strb_q.r_out;
  assign bus.MAR_enable     = strb_q.mar_enable;
  assign bus.PC_enable      = strb_q.pc_enable;
  assign bus.IncPC          = strb_q.inc_pc;
  assign bus.MDR_enable     = strb_q.mdr_enable;
  assign bus.MDR_read       = strb_q.mdr_read;
  assign bus.IR_enable      = strb_q.ir_enable;
  assign bus.Y_enable       = strb_q.y_enable;
  assign bus.ZHighIn        = strb_q.zhigh_in;
  assign bus.ZLowIn         = strb_q.zlow_in;
  assign bus.HIin           = strb_q.hi_in;
  assign bus.LOin           = strb_q.lo_in;
  assign bus.RAM_write      = strb_q.ram_write;
  assign bus.Gra            = strb_q.gra;
  assign bus.Grb            = strb_q.grb;
  assign bus.Grc            = strb_q.grc;
  assign bus.R_enable       = strb_q.r_enable;
  assign bus.CON_enable     = strb_q.con_enable;
  assign bus.OutPort_enable = strb_q.outport_enable;
  assign bus.R_enableIn     = rin_q;
  assign bus.Run            = run_q;
  assign bus.Illegal        = illegal_q;
  assign bus.Instr_count    = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer_p.sv
// Scoreboard bench: stimulus queues the expected strobe set for each cycle,
// a negedge monitor pops and compares against the sequencer outputs.
module tb_cpu_sequencer_p;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_sequencer_p_if #(.REG_COUNT(16), .CNT_WIDTH(32)) bus ();

  cpu_sequencer_p #(.REG_COUNT(16), .JAL_REG(15), .CNT_WIDTH(32)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  localparam logic [27:0] PCO  = 28'd1 << 0,  ZHO  = 28'd1 << 1,  ZLO  = 28'd1 << 2;
  localparam logic [27:0] MDRO = 28'd1 << 3,  HIO  = 28'd1 << 4,  LOO  = 28'd1 << 5;
  localparam logic [27:0] INO  = 28'd1 << 6,  CO   = 28'd1 << 7,  BAO  = 28'd1 << 8;
  localparam logic [27:0] RO   = 28'd1 << 9,  MARE = 28'd1 << 10, PCE  = 28'd1 << 11;
  localparam logic [27:0] INCP = 28'd1 << 12, MDRE = 28'd1 << 13, MDRR = 28'd1 << 14;
  localparam logic [27:0] IRE  = 28'd1 << 15, YE   = 28'd1 << 16, ZHI  = 28'd1 << 17;
  localparam logic [27:0] ZLI  = 28'd1 << 18, HII  = 28'd1 << 19, LOI  = 28'd1 << 20;
  localparam logic [27:0] RAMW = 28'd1 << 21, GRA  = 28'd1 << 22, GRB  = 28'd1 << 23;
  localparam logic [27:0] GRC  = 28'd1 << 24, RE   = 28'd1 << 25, CONE = 28'd1 << 26;
  localparam logic [27:0] OUTE = 28'd1 << 27;
  localparam logic [27:0] F0M = PCO | MARE | INCP | PCE;
  localparam logic [27:0] F1M = MDRR | MDRE;
  localparam logic [27:0] F2M = MDRO | IRE;

  logic [27:0] dut_strobes;
  assign dut_strobes = {bus.OutPort_enable, bus.CON_enable, bus.R_enable, bus.Grc, bus.Grb,
                        bus.Gra, bus.RAM_write, bus.LOin, bus.HIin, bus.ZLowIn, bus.ZHighIn,
                        bus.Y_enable, bus.IR_enable, bus.MDR_read, bus.MDR_enable, bus.IncPC,
                        bus.PC_enable, bus.MAR_enable, bus.Rout, bus.BAout, bus.Cout,
                        bus.InPortout, bus.LOout, bus.HIout, bus.MDRout, bus.ZLowout,
                        bus.ZHighout, bus.PCout};

  typedef struct {
    logic [27:0] s;
    logic [15:0] r;
    logic        run;
    logic        ill;
    logic [31:0] cnt;
    int          tag;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          tag = 0;
  logic [31:0] exp_cnt = 0;
  logic        exp_run = 1'b1;
  logic        exp_ill = 1'b0;

  task automatic expect_now(input logic [27:0] s, input logic [15:0] r);
    exp_t e;
    e.s = s; e.r = r; e.run = exp_run; e.ill = exp_ill; e.cnt = exp_cnt; e.tag = tag;
    tag++;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [27:0] s, input logic [15:0] r);
    @(posedge clk); #1;
    expect_now(s, r);
  endtask

  task automatic do_reset(input logic with_stop);
    @(posedge clk); #1;
    rst = 1'b1; bus.Stop = with_stop;
    exp_cnt = 0; exp_ill = 1'b0; exp_run = 1'b1;
    expect_now('0, '0);
    @(posedge clk); #1;
    expect_now('0, '0);
    rst = 1'b0; bus.Stop = 1'b0;
    $display("reset released stop_with_reset=%0b", with_stop);
  endtask

  task automatic do_instr(input logic [4:0] op, input int wf, input int wm, input logic con,
                          input int stop_step, input logic rst_wait);
    logic [27:0] steps [0:4];
    int   n;
    int   widx;
    logic ill;
    logic halting;
    n = 0; widx = -1;
    for (int i = 0; i < 5; i++) steps[i] = '0;
    ill     = (op == 5'b10110) || (op >= 5'b11100);
    halting = ill || (op == 5'b11011);
    bus.IR = {op, 27'($urandom)}; bus.CON_FF = con; bus.Mem_ready = 1'b1;
    cyc(F0M, '0);
    for (int k = 0; k <= wf; k++) begin
      cyc(F1M, '0);
      bus.Mem_ready = (k == wf);
    end
    cyc(F2M, '0);
    cyc('0, '0);
    if (halting) begin
      exp_run = 1'b0; exp_ill = ill;
      repeat (3) cyc('0, '0);
      $display("instr op=%b -> halt illegal=%0b cnt=%0d", op, ill, exp_cnt);
      return;
    end
    case (op)
      5'b00001, 5'b00010, 5'b00101, 5'b00110, 5'b01010, 5'b01011, 5'b01100, 5'b01101: begin
        n = 3; steps[0] = GRB|RO|YE; steps[1] = GRC|RO|ZHI|ZLI; steps[2] = ZLO|GRA|RE;
      end
      5'b00011, 5'b00100: begin
        n = 4; steps[0] = GRB|RO|YE; steps[1] = GRC|RO|ZHI|ZLI;
        steps[2] = ZLO|LOI; steps[3] = ZHO|HII;
      end
      5'b00111, 5'b01000: begin
        n = 2; steps[0] = GRB|RO|ZHI|ZLI; steps[1] = ZLO|GRA|RE;
      end
      5'b01111, 5'b10000, 5'b10001: begin
        n = 3; steps[0] = GRB|RO|YE; steps[1] = CO|ZHI|ZLI; steps[2] = ZLO|GRA|RE;
      end
      5'b01001: begin
        n = 3; steps[0] = GRB|BAO|YE; steps[1] = CO|ZHI|ZLI; steps[2] = ZLO|GRA|RE;
      end
      5'b00000: begin
        n = 5; widx = 3; steps[0] = GRB|BAO|YE; steps[1] = CO|ZHI|ZLI; steps[2] = ZLO|MARE;
        steps[3] = MDRR|MDRE; steps[4] = MDRO|GRA|RE;
      end
      5'b01110: begin
        n = 5; widx = 4; steps[0] = GRB|BAO|YE; steps[1] = CO|ZHI|ZLI; steps[2] = ZLO|MARE;
        steps[3] = GRA|RO|MDRE; steps[4] = MDRO|RAMW;
      end
      5'b10010: begin
        n = 4; steps[0] = GRA|RO|CONE; steps[1] = PCO|YE; steps[2] = CO|ZHI|ZLI;
        steps[3] = con ? (ZLO|PCE) : ZLO;
      end
      5'b10011: begin n = 1; steps[0] = GRA|RO|PCE; end
      5'b10100: begin n = 2; steps[0] = PCO; steps[1] = GRA|RO|PCE; end
      5'b10101: begin n = 1; steps[0] = GRA|RE|HIO; end
      5'b10111: begin n = 1; steps[0] = GRA|RE|LOO; end
      5'b11000: begin n = 1; steps[0] = GRA|RE|INO; end
      5'b11001: begin n = 1; steps[0] = GRA|RO|OUTE; end
      default:  begin n = 1; steps[0] = '0; end
    endcase
    for (int i = 0; i < n; i++) begin
      if (i == widx) begin
        for (int k = 0; k <= wm; k++) begin
          if (rst_wait && k == 1) begin
            @(posedge clk); #1;
            rst = 1'b1;
            exp_cnt = 0; exp_ill = 1'b0; exp_run = 1'b1;
            expect_now('0, '0);
            @(posedge clk); #1;
            expect_now('0, '0);
            rst = 1'b0; bus.Mem_ready = 1'b1;
            $display("instr op=%b interrupted by reset in memory wait", op);
            return;
          end
          cyc(steps[i], '0);
          bus.Mem_ready = (k == wm);
        end
      end else begin
        cyc(steps[i], (op == 5'b10100 && i == 0) ? 16'h8000 : 16'h0000);
        bus.Stop = (i == stop_step);
      end
    end
    bus.Stop = 1'b0;
    exp_cnt++;
    if (stop_step >= 0) begin
      exp_run = 1'b0;
      repeat (3) cyc('0, '0);
    end
    $display("instr op=%b wf=%0d wm=%0d con=%0b stop=%0d cnt=%0d", op, wf, wm, con,
             stop_step, exp_cnt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (dut_strobes !== e.s || bus.R_enableIn !== e.r || bus.Run !== e.run ||
            bus.Illegal !== e.ill || bus.Instr_count !== e.cnt) begin
          failures++;
          $display("FAIL cycle%0d strobes got=%h exp=%h rin got=%h exp=%h run got=%b exp=%b ill got=%b exp=%b cnt got=%0d exp=%0d",
                   e.tag, dut_strobes, e.s, bus.R_enableIn, e.r, bus.Run, e.run,
                   bus.Illegal, e.ill, bus.Instr_count, e.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    bus.IR = '0; bus.CON_FF = 1'b0; bus.Mem_ready = 1'b1; bus.Stop = 1'b0;
    do_reset(1'b0);
    do_instr(5'b00001, 0, 0, 1'b0, -1, 1'b0);   // add
    do_instr(5'b00000, 3, 3, 1'b0, -1, 1'b0);   // ld, 3 waits in F1 and T6
    do_instr(5'b10010, 0, 0, 1'b0, -1, 1'b0);   // br not taken
    do_instr(5'b10010, 0, 0, 1'b1, -1, 1'b0);   // br taken
    do_instr(5'b10100, 0, 0, 1'b0, -1, 1'b0);   // jal
    do_instr(5'b00011, 0, 0, 1'b0, -1, 1'b0);   // mul
    do_instr(5'b00100, 1, 0, 1'b0, -1, 1'b0);   // div
    do_instr(5'b00111, 0, 0, 1'b0, -1, 1'b0);   // neg
    do_instr(5'b01000, 0, 0, 1'b0, -1, 1'b0);   // not
    do_instr(5'b01111, 0, 0, 1'b0, -1, 1'b0);   // addi
    do_instr(5'b01001, 0, 0, 1'b0, -1, 1'b0);   // ldi
    do_instr(5'b10011, 0, 0, 1'b0, -1, 1'b0);   // jr
    do_instr(5'b10101, 0, 0, 1'b0, -1, 1'b0);   // mfhi
    do_instr(5'b10111, 0, 0, 1'b0, -1, 1'b0);   // mflo
    do_instr(5'b11000, 0, 0, 1'b0, -1, 1'b0);   // in
    do_instr(5'b11001, 0, 0, 1'b0, -1, 1'b0);   // out
    do_instr(5'b11010, 0, 0, 1'b0, -1, 1'b0);   // nop
    do_instr(5'b01101, 0, 0, 1'b0, -1, 1'b0);   // ror
    do_instr(5'b01110, 0, 1, 1'b0, -1, 1'b0);   // st, one write wait
    do_instr(5'b00010, 0, 0, 1'b0,  1, 1'b0);   // sub, Stop in T4
    do_reset(1'b1);
    do_instr(5'b00101, 0, 0, 1'b0, -1, 1'b0);   // and
    do_instr(5'b00110, 0, 0, 1'b0, -1, 1'b0);   // or: latch was cleared
    do_instr(5'b11110, 0, 0, 1'b0, -1, 1'b0);   // illegal
    do_reset(1'b0);
    do_instr(5'b11011, 0, 0, 1'b0, -1, 1'b0);   // halt
    do_reset(1'b0);
    do_instr(5'b00001, 0, 0, 1'b0, -1, 1'b0);   // add
    do_instr(5'b01110, 0, 3, 1'b0, -1, 1'b1);   // st, reset mid T7
    do_instr(5'b11010, 0, 0, 1'b0, -1, 1'b0);   // nop
    cyc(F0M, '0);
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
